// File: rtl/cdb_arbiter.sv
// CDB transmit end: per-FU one-entry holding registers, round-robin selection of up to SS
// held results per cycle, and SS registered broadcast lanes.

module cdb_hold_slot #(
    parameter int PREG_W   = 6,
    parameter int ROB_ID_W = 8,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    input  logic                grant,
    input  logic [PREG_W-1:0]   in_rd,
    input  logic [ROB_ID_W-1:0] in_rob_id,
    input  logic [DATA_W-1:0]   in_value,
    output logic                ready,
    output logic                hold_v,
    output logic [PREG_W-1:0]   out_rd,
    output logic [ROB_ID_W-1:0] out_rob_id,
    output logic [DATA_W-1:0]   out_value
);
    logic                v_q, v_d;
    logic [PREG_W-1:0]   rd_q, rd_d;
    logic [ROB_ID_W-1:0] rob_q, rob_d;
    logic [DATA_W-1:0]   val_q, val_d;

    // A granted entry frees its slot this cycle, so a new result can land with no bubble.
    assign ready = !flush && (!v_q || grant);

    always_comb begin
        v_d   = v_q;
        rd_d  = rd_q;
        rob_d = rob_q;
        val_d = val_q;
        if (grant) v_d = 1'b0;
        if (in_valid && ready) begin
            v_d   = 1'b1;
            rd_d  = in_rd;
            rob_d = in_rob_id;
            val_d = in_value;
        end
        if (flush) v_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= 1'b0;
            rd_q  <= '0;
            rob_q <= '0;
            val_q <= '0;
        end else begin
            v_q   <= v_d;
            rd_q  <= rd_d;
            rob_q <= rob_d;
            val_q <= val_d;
        end
    end

    assign hold_v     = v_q;
    assign out_rd     = rd_q;
    assign out_rob_id = rob_q;
    assign out_value  = val_q;
endmodule

module cdb_lane_reg #(
    parameter int PREG_W   = 6,
    parameter int ROB_ID_W = 8,
    parameter int DATA_W   = 32,
    parameter int FIDX_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [PREG_W-1:0]   in_rd,
    input  logic [ROB_ID_W-1:0] in_rob_id,
    input  logic [DATA_W-1:0]   in_value,
    input  logic [FIDX_W-1:0]   in_fu_idx,
    output logic                out_valid,
    output logic [PREG_W-1:0]   out_rd,
    output logic [ROB_ID_W-1:0] out_rob_id,
    output logic [DATA_W-1:0]   out_value,
    output logic [FIDX_W-1:0]   out_fu_idx
);
    logic                valid_q, valid_d;
    logic [PREG_W-1:0]   rd_q, rd_d;
    logic [ROB_ID_W-1:0] rob_q, rob_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic [FIDX_W-1:0]   fu_q, fu_d;

    always_comb begin
        valid_d = in_valid && !flush;
        rd_d    = rd_q;
        rob_d   = rob_q;
        val_d   = val_q;
        fu_d    = fu_q;
        if (valid_d) begin
            rd_d  = in_rd;
            rob_d = in_rob_id;
            // p0 is hardwired zero: the ROB still needs the completion, the value is dropped.
            val_d = (in_rd == '0) ? '0 : in_value;
            fu_d  = in_fu_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            rob_q   <= '0;
            val_q   <= '0;
            fu_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            rob_q   <= rob_d;
            val_q   <= val_d;
            fu_q    <= fu_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_rd     = rd_q;
    assign out_rob_id = rob_q;
    assign out_value  = val_q;
    assign out_fu_idx = fu_q;
endmodule

module cdb_arbiter #(
    parameter int SS       = 2,
    parameter int FU_COUNT = 4,
    parameter int PREG_W   = 6,
    parameter int ROB_ID_W = 8,
    parameter int DATA_W   = 32,
    localparam int FIDX_W  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1,
    localparam int LANE_W  = (SS > 1) ? $clog2(SS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [FU_COUNT-1:0]          fu_valid,
    output logic [FU_COUNT-1:0]          fu_ready,
    input  logic [FU_COUNT*PREG_W-1:0]   fu_rd,
    input  logic [FU_COUNT*ROB_ID_W-1:0] fu_rob_id,
    input  logic [FU_COUNT*DATA_W-1:0]   fu_value,
    output logic [SS-1:0]                cdb_valid,
    output logic [SS*PREG_W-1:0]         cdb_rd,
    output logic [SS*ROB_ID_W-1:0]       cdb_rob_id,
    output logic [SS*DATA_W-1:0]         cdb_value,
    output logic [SS*FIDX_W-1:0]         cdb_fu_idx
);
    logic [FU_COUNT-1:0]               hold_v, grant;
    logic [FU_COUNT-1:0][PREG_W-1:0]   hold_rd;
    logic [FU_COUNT-1:0][ROB_ID_W-1:0] hold_rob;
    logic [FU_COUNT-1:0][DATA_W-1:0]   hold_val;

    logic [SS-1:0]                     lane_used;
    logic [SS-1:0][FIDX_W-1:0]         lane_sel;
    logic [SS-1:0][PREG_W-1:0]         lane_rd;
    logic [SS-1:0][ROB_ID_W-1:0]       lane_rob;
    logic [SS-1:0][DATA_W-1:0]         lane_val;

    logic [FIDX_W-1:0]                 rr_ptr_q, rr_ptr_d;

    for (genvar i = 0; i < FU_COUNT; i++) begin : g_slot
        cdb_hold_slot #(.PREG_W(PREG_W), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .in_valid   (fu_valid[i]),
            .grant      (grant[i]),
            .in_rd      (fu_rd[i*PREG_W +: PREG_W]),
            .in_rob_id  (fu_rob_id[i*ROB_ID_W +: ROB_ID_W]),
            .in_value   (fu_value[i*DATA_W +: DATA_W]),
            .ready      (fu_ready[i]),
            .hold_v     (hold_v[i]),
            .out_rd     (hold_rd[i]),
            .out_rob_id (hold_rob[i]),
            .out_value  (hold_val[i])
        );
    end

    // Round-robin scan from rr_ptr; the first SS occupied slots fill lanes in scan order.
    always_comb begin
        int                n;
        int                p;
        int                last;
        logic [FIDX_W-1:0] idx;
        grant     = '0;
        lane_used = '0;
        lane_sel  = '0;
        rr_ptr_d  = rr_ptr_q;
        n         = 0;
        last      = 0;
        idx       = '0;
        for (int j = 0; j < FU_COUNT; j++) begin
            p = int'(rr_ptr_q) + j;
            if (p >= FU_COUNT) p = p - FU_COUNT;
            idx = FIDX_W'(p);
            if (hold_v[idx] && n < SS) begin
                grant[idx]                = 1'b1;
                lane_used[LANE_W'(n)]     = 1'b1;
                lane_sel[LANE_W'(n)]      = idx;
                n                         = n + 1;
                last                      = p;
            end
        end
        if (n > 0) rr_ptr_d = (last + 1 >= FU_COUNT) ? '0 : FIDX_W'(last + 1);
        if (flush) rr_ptr_d = '0;
    end

    always_comb begin
        lane_rd  = '0;
        lane_rob = '0;
        lane_val = '0;
        for (int k = 0; k < SS; k++) begin
            lane_rd[k]  = hold_rd[lane_sel[k]];
            lane_rob[k] = hold_rob[lane_sel[k]];
            lane_val[k] = hold_val[lane_sel[k]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

    for (genvar k = 0; k < SS; k++) begin : g_lane
        cdb_lane_reg #(.PREG_W(PREG_W), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W),
                       .FIDX_W(FIDX_W)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .in_valid   (lane_used[k]),
            .in_rd      (lane_rd[k]),
            .in_rob_id  (lane_rob[k]),
            .in_value   (lane_val[k]),
            .in_fu_idx  (lane_sel[k]),
            .out_valid  (cdb_valid[k]),
            .out_rd     (cdb_rd[k*PREG_W +: PREG_W]),
            .out_rob_id (cdb_rob_id[k*ROB_ID_W +: ROB_ID_W]),
            .out_value  (cdb_value[k*DATA_W +: DATA_W]),
            .out_fu_idx (cdb_fu_idx[k*FIDX_W +: FIDX_W])
        );
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for single/rd0/wrap/flush cases, plus
// hand sequences for reset, full contention with a scoreboard, and mid-run reset.

module tb_cdb_arbiter;
    logic         clk = 1'b0;
    logic         rst, flush;
    logic [3:0]   fu_valid, fu_ready;
    logic [23:0]  fu_rd;
    logic [31:0]  fu_rob_id;
    logic [127:0] fu_value;
    logic [1:0]   cdb_valid;
    logic [11:0]  cdb_rd;
    logic [15:0]  cdb_rob_id;
    logic [63:0]  cdb_value;
    logic [3:0]   cdb_fu_idx;

    int nchk = 0;
    int nerr = 0;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_rd(fu_rd), .fu_rob_id(fu_rob_id), .fu_value(fu_value),
        .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_rob_id(cdb_rob_id),
        .cdb_value(cdb_value), .cdb_fu_idx(cdb_fu_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             flush;
        logic [3:0]       fv;
        logic [3:0][5:0]  rd;
        logic [3:0][7:0]  rob;
        logic [3:0][31:0] val;
        logic [3:0]       e_rdy;
        logic [1:0]       e_cv;
        logic [1:0][5:0]  e_rd;
        logic [1:0][7:0]  e_rob;
        logic [1:0][31:0] e_val;
        logic [1:0][1:0]  e_fu;
    } vec_t;

    vec_t tbl [0:15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fl, input logic [3:0] fv, input logic [3:0] rdy,
                                input logic [1:0] cv);
        vec_t v;
        v.flush = fl;    v.fv = fv;    v.e_rdy = rdy; v.e_cv = cv;
        v.rd = '0;       v.rob = '0;   v.val = '0;
        v.e_rd = '0;     v.e_rob = '0; v.e_val = '0; v.e_fu = '0;
        return v;
    endfunction

    int          seq [4];
    logic [7:0]  q_rob [4][$];
    logic [31:0] q_val [4][$];

    initial begin
        rst = 1'b1; flush = 1'b0; fu_valid = '0;
        fu_rd = '0; fu_rob_id = '0; fu_value = '0;

        // Reset: two cycles, then deassert.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst cdb_valid", 64'(cdb_valid), 64'h0);
        chk("rst fu_ready", 64'(fu_ready), 64'hF);
        chk("rst cdb_rd", 64'(cdb_rd), 64'h0);
        chk("rst cdb_rob_id", 64'(cdb_rob_id), 64'h0);
        chk("rst cdb_value", cdb_value, 64'h0);
        chk("rst cdb_fu_idx", 64'(cdb_fu_idx), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-rst fu_ready", 64'(fu_ready), 64'hF);
        chk("post-rst cdb_valid", 64'(cdb_valid), 64'h0);

        // Single result from FU2.
        tbl[0] = mk(0, 4'b0100, 4'hF, 2'b00);
        tbl[0].rd[2] = 6'd5; tbl[0].rob[2] = 8'd3; tbl[0].val[2] = 32'hDEADBEEF;
        tbl[1] = mk(0, 4'b0000, 4'hF, 2'b01);
        tbl[1].e_rd[0] = 6'd5; tbl[1].e_rob[0] = 8'd3; tbl[1].e_val[0] = 32'hDEADBEEF;
        tbl[1].e_fu[0] = 2'd2;
        tbl[2] = mk(0, 4'b0000, 4'hF, 2'b00);
        // rd==0 from FU1: broadcast with value forced to zero.
        tbl[3] = mk(0, 4'b0010, 4'hF, 2'b00);
        tbl[3].rd[1] = 6'd0; tbl[3].rob[1] = 8'h44; tbl[3].val[1] = 32'h1234;
        tbl[4] = mk(0, 4'b0000, 4'hF, 2'b01);
        tbl[4].e_rd[0] = 6'd0; tbl[4].e_rob[0] = 8'h44; tbl[4].e_val[0] = 32'h0;
        tbl[4].e_fu[0] = 2'd1;
        // Steer rr_ptr to 3 via FU2, while FU3 and FU0 load.
        tbl[5] = mk(0, 4'b0100, 4'hF, 2'b00);
        tbl[5].rd[2] = 6'd7; tbl[5].rob[2] = 8'h10; tbl[5].val[2] = 32'h7777;
        tbl[6] = mk(0, 4'b1001, 4'hF, 2'b01);
        tbl[6].rd[0] = 6'd1; tbl[6].rob[0] = 8'h30; tbl[6].val[0] = 32'h30303030;
        tbl[6].rd[3] = 6'd9; tbl[6].rob[3] = 8'h33; tbl[6].val[3] = 32'h33333333;
        tbl[6].e_rd[0] = 6'd7; tbl[6].e_rob[0] = 8'h10; tbl[6].e_val[0] = 32'h7777;
        tbl[6].e_fu[0] = 2'd2;
        // Wrap: rr_ptr=3 -> lane0=FU3, lane1=FU0, rr_ptr becomes 1.
        tbl[7] = mk(0, 4'b0000, 4'hF, 2'b11);
        tbl[7].e_rd[0] = 6'd9; tbl[7].e_rob[0] = 8'h33; tbl[7].e_val[0] = 32'h33333333;
        tbl[7].e_fu[0] = 2'd3;
        tbl[7].e_rd[1] = 6'd1; tbl[7].e_rob[1] = 8'h30; tbl[7].e_val[1] = 32'h30303030;
        tbl[7].e_fu[1] = 2'd0;
        // rr_ptr=1 with FU0..2 held: FU1,FU2 first, FU0 backpressured.
        tbl[8] = mk(0, 4'b0111, 4'hF, 2'b00);
        tbl[8].rd[0] = 6'd11; tbl[8].rob[0] = 8'h50; tbl[8].val[0] = 32'hA0A0A0A0;
        tbl[8].rd[1] = 6'd12; tbl[8].rob[1] = 8'h51; tbl[8].val[1] = 32'hB1B1B1B1;
        tbl[8].rd[2] = 6'd13; tbl[8].rob[2] = 8'h52; tbl[8].val[2] = 32'hC2C2C2C2;
        tbl[9] = mk(0, 4'b0000, 4'b1110, 2'b11);
        tbl[9].e_rd[0] = 6'd12; tbl[9].e_rob[0] = 8'h51; tbl[9].e_val[0] = 32'hB1B1B1B1;
        tbl[9].e_fu[0] = 2'd1;
        tbl[9].e_rd[1] = 6'd13; tbl[9].e_rob[1] = 8'h52; tbl[9].e_val[1] = 32'hC2C2C2C2;
        tbl[9].e_fu[1] = 2'd2;
        tbl[10] = mk(0, 4'b0000, 4'hF, 2'b01);
        tbl[10].e_rd[0] = 6'd11; tbl[10].e_rob[0] = 8'h50; tbl[10].e_val[0] = 32'hA0A0A0A0;
        tbl[10].e_fu[0] = 2'd0;
        // Flush with FU0,FU3 holding: ready drops, held results vanish, rr_ptr back to 0.
        tbl[11] = mk(0, 4'b1001, 4'hF, 2'b00);
        tbl[11].rd[0] = 6'd20; tbl[11].rob[0] = 8'h60; tbl[11].val[0] = 32'h60606060;
        tbl[11].rd[3] = 6'd23; tbl[11].rob[3] = 8'h63; tbl[11].val[3] = 32'h63636363;
        tbl[12] = mk(1, 4'b1111, 4'h0, 2'b00);
        tbl[13] = mk(0, 4'b0000, 4'hF, 2'b00);
        tbl[14] = mk(0, 4'b1001, 4'hF, 2'b00);
        tbl[14].rd[0] = 6'd2; tbl[14].rob[0] = 8'h70; tbl[14].val[0] = 32'h70707070;
        tbl[14].rd[3] = 6'd4; tbl[14].rob[3] = 8'h73; tbl[14].val[3] = 32'h73737373;
        tbl[15] = mk(0, 4'b0000, 4'hF, 2'b11);
        tbl[15].e_rd[0] = 6'd2; tbl[15].e_rob[0] = 8'h70; tbl[15].e_val[0] = 32'h70707070;
        tbl[15].e_fu[0] = 2'd0;
        tbl[15].e_rd[1] = 6'd4; tbl[15].e_rob[1] = 8'h73; tbl[15].e_val[1] = 32'h73737373;
        tbl[15].e_fu[1] = 2'd3;

        for (int i = 0; i < 16; i++) begin
            flush = tbl[i].flush; fu_valid = tbl[i].fv;
            fu_rd = tbl[i].rd; fu_rob_id = tbl[i].rob; fu_value = tbl[i].val;
            #1;
            chk($sformatf("v%0d fu_ready", i), 64'(fu_ready), 64'(tbl[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d cdb_valid", i), 64'(cdb_valid), 64'(tbl[i].e_cv));
            for (int k = 0; k < 2; k++) begin
                if (tbl[i].e_cv[k]) begin
                    chk($sformatf("v%0d l%0d rd", i, k), 64'(cdb_rd[k*6 +: 6]), 64'(tbl[i].e_rd[k]));
                    chk($sformatf("v%0d l%0d rob", i, k), 64'(cdb_rob_id[k*8 +: 8]), 64'(tbl[i].e_rob[k]));
                    chk($sformatf("v%0d l%0d val", i, k), 64'(cdb_value[k*32 +: 32]), 64'(tbl[i].e_val[k]));
                    chk($sformatf("v%0d l%0d fu", i, k), 64'(cdb_fu_idx[k*2 +: 2]), 64'(tbl[i].e_fu[k]));
                end
            end
        end
        flush = 1'b0; fu_valid = '0;

        // Full contention from rr_ptr=0: lanes alternate (FU0,FU1) / (FU2,FU3).
        for (int i = 0; i < 4; i++) seq[i] = 0;
        for (int c = 0; c <= 10; c++) begin
            fu_valid = (c < 8) ? 4'hF : 4'h0;
            for (int i = 0; i < 4; i++) begin
                fu_rd[i*6 +: 6]       = 6'(i + 1);
                fu_rob_id[i*8 +: 8]   = 8'((i << 6) | seq[i]);
                fu_value[i*32 +: 32]  = 32'hF000_0000 | 32'(i << 8) | 32'(seq[i]);
            end
            #1;
            if (c < 8)
                chk($sformatf("t3 c%0d fu_ready", c), 64'(fu_ready),
                    (c == 0) ? 64'hF : ((c % 2 == 1) ? 64'h3 : 64'hC));
            for (int i = 0; i < 4; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    q_rob[i].push_back(fu_rob_id[i*8 +: 8]);
                    q_val[i].push_back(fu_value[i*32 +: 32]);
                    seq[i]++;
                end
            end
            @(posedge clk); #1;
            chk($sformatf("t3 c%0d cdb_valid", c), 64'(cdb_valid),
                (c == 0 || c == 10) ? 64'h0 : 64'h3);
            for (int k = 0; k < 2; k++) begin
                if (cdb_valid[k]) begin
                    int f;
                    f = int'(cdb_fu_idx[k*2 +: 2]);
                    chk($sformatf("t3 c%0d l%0d fu", c, k), 64'(f),
                        64'((c % 2 == 1) ? k : k + 2));
                    if (q_rob[f].size() == 0) begin
                        nchk++; nerr++;
                        $display("FAIL t3 c%0d l%0d duplicate: fu %0d got rob %0h expected none", c, k, f,
                                 cdb_rob_id[k*8 +: 8]);
                    end else begin
                        chk($sformatf("t3 c%0d l%0d rob", c, k), 64'(cdb_rob_id[k*8 +: 8]),
                            64'(q_rob[f].pop_front()));
                        chk($sformatf("t3 c%0d l%0d val", c, k), 64'(cdb_value[k*32 +: 32]),
                            64'(q_val[f].pop_front()));
                    end
                end
            end
        end
        chk("t3 leftover", 64'(q_rob[0].size() + q_rob[1].size() + q_rob[2].size() + q_rob[3].size()),
            64'h0);
        chk("t3 accepted", 64'(seq[0] + seq[1] + seq[2] + seq[3]), 64'd18);

        // Reset mid-operation: held FU1 result is dropped and payload cleared.
        fu_valid = 4'b0010;
        fu_rd[6 +: 6] = 6'd33; fu_rob_id[8 +: 8] = 8'h99; fu_value[32 +: 32] = 32'h5555;
        @(posedge clk); #1;
        fu_valid = '0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid-rst cdb_valid", 64'(cdb_valid), 64'h0);
        chk("mid-rst cdb_rob_id", 64'(cdb_rob_id), 64'h0);
        @(posedge clk); #1;
        chk("mid-rst dropped", 64'(cdb_valid), 64'h0);
        chk("mid-rst fu_ready", 64'(fu_ready), 64'hF);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
